// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: sequences one div/mod op at a time between the issue stage
// and a fixed-latency iterative 32-bit divider. It resolves divide-by-zero and
// signed overflow in one cycle, and holds the result for writeback under a
// valid/ready handshake.
//
// Ports:
//   clk, rstn                 clock (rising edge), async active-low reset
//   ISS_div_en                request valid from issue
//   ISS_a, ISS_b              dividend / divisor (sampled on accept only)
//   ISS_div_signed            1 = signed op
//   ISS_div_op                0 = quotient, 1 = remainder
//   ISS_rd                    destination tag
//   ISS_flush                 kill the in-flight op (wins over accept/handshake)
//   div_ready                 controller idle, can accept
//   div_stall                 issue must hold (combinational)
//   div_start                 one-cycle start pulse to the divider
//   div_a, div_b, div_signed  registered operands to the divider
//   div_quo, div_rem          divider results
//   WB_valid, WB_ready        writeback handshake
//   WB_rd, WB_data            result tag / data
module div_issue_ctrl #(
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned TAG_W      = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ISS_div_en,
  input  logic [31:0]      ISS_a,
  input  logic [31:0]      ISS_b,
  input  logic             ISS_div_signed,
  input  logic             ISS_div_op,
  input  logic [TAG_W-1:0] ISS_rd,
  input  logic             ISS_flush,
  output logic             div_ready,
  output logic             div_stall,
  output logic             div_start,
  output logic [31:0]      div_a,
  output logic [31:0]      div_b,
  output logic             div_signed,
  input  logic [31:0]      div_quo,
  input  logic [31:0]      div_rem,
  output logic             WB_valid,
  input  logic             WB_ready,
  output logic [TAG_W-1:0] WB_rd,
  output logic [31:0]      WB_data
);

  localparam int unsigned CNT_W = $clog2(DIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               start_q, start_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic               signed_q, signed_d;
  logic               op_q, op_d;
  logic [TAG_W-1:0]   rd_q, rd_d;
  logic               wb_valid_q, wb_valid_d;
  logic [31:0]        wb_data_q, wb_data_d;

  logic               accept_c;
  logic               b_zero_c;
  logic               ovf_c;
  logic [31:0]        fast_data_c;

  // Fast-path detection on the live issue operands (only meaningful on accept)
  always_comb begin
    b_zero_c    = (ISS_b == 32'd0);
    ovf_c       = ISS_div_signed & (ISS_a == 32'h8000_0000) & (ISS_b == 32'hFFFF_FFFF);
    fast_data_c = 32'd0;
    if (b_zero_c) begin
      fast_data_c = ISS_div_op ? ISS_a : 32'hFFFF_FFFF;
    end else if (ovf_c) begin
      fast_data_c = ISS_div_op ? 32'd0 : 32'h8000_0000;
    end
  end

  assign accept_c = (state_q == S_IDLE) & ISS_div_en & ~ISS_flush;

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    start_d    = 1'b0;
    a_d        = a_q;
    b_d        = b_q;
    signed_d   = signed_q;
    op_d       = op_q;
    rd_d       = rd_q;
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          a_d      = ISS_a;
          b_d      = ISS_b;
          signed_d = ISS_div_signed;
          op_d     = ISS_div_op;
          rd_d     = ISS_rd;
          cnt_d    = '0;
          if (b_zero_c | ovf_c) begin
            wb_data_d  = fast_data_c;
            wb_valid_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            start_d = 1'b1;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (ISS_flush) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          // Divider result is valid in the last counted cycle
          if (cnt_q == CNT_LAST) begin
            wb_data_d  = op_q ? div_rem : div_quo;
            wb_valid_d = 1'b1;
            state_d    = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Flush takes priority over a simultaneous handshake
        if (ISS_flush || WB_ready) begin
          wb_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        wb_valid_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      start_q    <= 1'b0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      signed_q   <= 1'b0;
      op_q       <= 1'b0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      start_q    <= start_d;
      a_q        <= a_d;
      b_q        <= b_d;
      signed_q   <= signed_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign div_ready  = (state_q == S_IDLE);
  assign div_stall  = ISS_div_en & ~div_ready;
  assign div_start  = start_q;
  assign div_a      = a_q;
  assign div_b      = b_q;
  assign div_signed = signed_q;
  assign WB_valid   = wb_valid_q;
  assign WB_rd      = rd_q;
  assign WB_data    = wb_data_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: directed vector table, hand-written flush /
// back-pressure / reset sequences, and randomized ops against a reference
// model of the divider and of the controller's result rules.
module tb_div_issue_ctrl;

  localparam int DC = 32;

  logic        clk;
  logic        rstn;
  logic        ISS_div_en;
  logic [31:0] ISS_a;
  logic [31:0] ISS_b;
  logic        ISS_div_signed;
  logic        ISS_div_op;
  logic [4:0]  ISS_rd;
  logic        ISS_flush;
  logic        div_ready;
  logic        div_stall;
  logic        div_start;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_signed;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic        WB_valid;
  logic        WB_ready;
  logic [4:0]  WB_rd;
  logic [31:0] WB_data;

  div_issue_ctrl #(.DIV_CYCLES(DC), .TAG_W(5)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .ISS_div_en     (ISS_div_en),
    .ISS_a          (ISS_a),
    .ISS_b          (ISS_b),
    .ISS_div_signed (ISS_div_signed),
    .ISS_div_op     (ISS_div_op),
    .ISS_rd         (ISS_rd),
    .ISS_flush      (ISS_flush),
    .div_ready      (div_ready),
    .div_stall      (div_stall),
    .div_start      (div_start),
    .div_a          (div_a),
    .div_b          (div_b),
    .div_signed     (div_signed),
    .div_quo        (div_quo),
    .div_rem        (div_rem),
    .WB_valid       (WB_valid),
    .WB_ready       (WB_ready),
    .WB_rd          (WB_rd),
    .WB_data        (WB_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference division result {quo, rem} following the architectural rules
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic signed [31:0] sa, sb, sq, sr;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'd0};
    if (s) begin
      sa = a;
      sb = b;
      sq = sa / sb;
      sr = sa % sb;
      return {sq, sr};
    end
    return {a / b, a % b};
  endfunction

  // Divider model: junk until DC cycles of the start pulse have elapsed,
  // counting the start cycle itself; restarts on every start.
  logic [31:0] dv_a, dv_b;
  logic        dv_s;
  int          dv_cnt = 0;
  int          n_start = 0;
  logic [63:0] dv_res;

  always @(posedge clk) begin
    if (div_start) begin
      dv_a   <= div_a;
      dv_b   <= div_b;
      dv_s   <= div_signed;
      dv_cnt <= 1;
    end else if (dv_cnt > 0 && dv_cnt < 1000) begin
      dv_cnt <= dv_cnt + 1;
    end
    n_start <= n_start + int'(div_start);
  end

  assign dv_res  = ref_div(dv_a, dv_b, dv_s);
  assign div_quo = (dv_cnt >= DC - 1) ? dv_res[63:32] : 32'hDEAD_BEEF;
  assign div_rem = (dv_cnt >= DC - 1) ? dv_res[31:0]  : 32'hBAD0_BAD0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic        op;
    logic [4:0]  rd;
    logic [31:0] exp;
    logic        fast;
  } vec_t;

  vec_t vecs[12];

  // Present a request and take it on the next edge; returns at the negedge after accept
  task automatic issue(input vec_t v, input string nm);
    @(negedge clk);
    chk({nm, ".ready"}, 32'(div_ready), 32'd1);
    ISS_a          = v.a;
    ISS_b          = v.b;
    ISS_div_signed = v.s;
    ISS_div_op     = v.op;
    ISS_rd         = v.rd;
    ISS_div_en     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ISS_div_en     = 1'b0;
    ISS_a          = $urandom;
    ISS_b          = $urandom;
    ISS_div_signed = 1'($urandom);
    ISS_div_op     = 1'($urandom);
    ISS_rd         = 5'($urandom);
    chk({nm, ".start"}, 32'(div_start), 32'(!v.fast));
    chk({nm, ".div_a"}, div_a, v.a);
    chk({nm, ".div_b"}, div_b, v.b);
    chk({nm, ".div_signed"}, 32'(div_signed), 32'(v.s));
  endtask

  // Wait (bounded) for WB_valid and check latency, data, tag and start count
  task automatic wait_wb(input vec_t v, input string nm, input int s0);
    int lat;
    lat = 1;
    while (!WB_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, ".latency"}, 32'(lat), v.fast ? 32'd1 : 32'(DC + 1));
    chk({nm, ".data"}, WB_data, v.exp);
    chk({nm, ".rd"}, 32'(WB_rd), 32'(v.rd));
    chk({nm, ".n_start"}, 32'(n_start - s0), v.fast ? 32'd0 : 32'd1);
  endtask

  task automatic handshake(input string nm);
    WB_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    WB_ready = 1'b0;
    chk({nm, ".wb_drop"}, 32'(WB_valid), 32'd0);
    chk({nm, ".idle"}, 32'(div_ready), 32'd1);
  endtask

  task automatic run_op(input vec_t v, input string nm, input int hold);
    int s0;
    s0 = n_start;
    issue(v, nm);
    wait_wb(v, nm, s0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, ".hold_valid"}, 32'(WB_valid), 32'd1);
      chk({nm, ".hold_data"}, WB_data, v.exp);
    end
    handshake(nm);
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic s,
                              input logic op, input logic [4:0] rd, input logic [31:0] exp,
                              input logic fast);
    vec_t v;
    v.a = a; v.b = b; v.s = s; v.op = op; v.rd = rd; v.exp = exp; v.fast = fast;
    return v;
  endfunction

  initial begin
    vec_t v;
    int   s0;
    logic saw;
    logic [63:0] r;

    vecs[0]  = mk(32'h0000_0100, 32'h0000_0011, 1'b0, 1'b0, 5'd3,  32'h0000_000F, 1'b0);
    vecs[1]  = mk(32'h0000_0100, 32'h0000_0011, 1'b0, 1'b1, 5'd3,  32'h0000_0001, 1'b0);
    vecs[2]  = mk(32'h8A73_2000, 32'hFFFF_F567, 1'b1, 1'b0, 5'd7,  32'h000B_1794, 1'b0);
    vecs[3]  = mk(32'h8A73_2000, 32'hFFFF_F567, 1'b1, 1'b1, 5'd8,  32'hFFFF_FF74, 1'b0);
    vecs[4]  = mk(32'h0000_1234, 32'h0000_0000, 1'b0, 1'b0, 5'd1,  32'hFFFF_FFFF, 1'b1);
    vecs[5]  = mk(32'h0000_1234, 32'h0000_0000, 1'b0, 1'b1, 5'd2,  32'h0000_1234, 1'b1);
    vecs[6]  = mk(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd31, 32'h8000_0000, 1'b1);
    vecs[7]  = mk(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd30, 32'h0000_0000, 1'b1);
    vecs[8]  = mk(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd4,  32'h0000_0000, 1'b0);
    vecs[9]  = mk(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd5,  32'h8000_0000, 1'b0);
    vecs[10] = mk(32'hFFFF_FFF9, 32'h0000_0000, 1'b1, 1'b1, 5'd9,  32'hFFFF_FFF9, 1'b1);
    vecs[11] = mk(32'hFFFF_FFF9, 32'h0000_0000, 1'b1, 1'b0, 5'd10, 32'hFFFF_FFFF, 1'b1);

    rstn = 1'b0; ISS_div_en = 1'b0; ISS_a = '0; ISS_b = '0; ISS_div_signed = 1'b0;
    ISS_div_op = 1'b0; ISS_rd = '0; ISS_flush = 1'b0; WB_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.ready", 32'(div_ready), 32'd1);
    chk("rst.wb_valid", 32'(WB_valid), 32'd0);
    chk("rst.start", 32'(div_start), 32'd0);
    chk("rst.div_a", div_a, 32'd0);
    chk("rst.div_b", div_b, 32'd0);
    chk("rst.wb_data", WB_data, 32'd0);
    chk("rst.wb_rd", 32'(WB_rd), 32'd0);
    chk("rst.div_signed", 32'(div_signed), 32'd0);
    rstn = 1'b1;

    // Directed table
    for (int i = 0; i < 12; i++) run_op(vecs[i], $sformatf("vec%0d", i), i % 3);

    // Flush in RUN, then check nothing ever comes out
    issue(vecs[0], "flushA");
    repeat (9) @(negedge clk);
    ISS_flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ISS_flush = 1'b0;
    chk("flushA.idle", 32'(div_ready), 32'd1);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      saw |= WB_valid;
    end
    chk("flushA.no_wb", 32'(saw), 32'd0);

    // Flush in RUN cycle 10, new op issued straight after
    issue(vecs[1], "flushB");
    repeat (9) @(negedge clk);
    ISS_flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ISS_flush = 1'b0;
    chk("flushB.idle", 32'(div_ready), 32'd1);
    chk("flushB.no_wb", 32'(WB_valid), 32'd0);
    run_op(vecs[3], "postflush", 0);

    // Flush with a request in IDLE: no accept
    @(negedge clk);
    s0 = n_start;
    ISS_a = 32'd100; ISS_b = 32'd7; ISS_div_en = 1'b1; ISS_flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ISS_div_en = 1'b0; ISS_flush = 1'b0;
    chk("idleflush.ready", 32'(div_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("idleflush.no_start", 32'(n_start - s0), 32'd0);
    chk("idleflush.no_wb", 32'(WB_valid), 32'd0);

    // Flush together with WB_ready in DONE
    s0 = n_start;
    issue(vecs[4], "doneflush");
    wait_wb(vecs[4], "doneflush", s0);
    WB_ready = 1'b1; ISS_flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    WB_ready = 1'b0; ISS_flush = 1'b0;
    chk("doneflush.wb_drop", 32'(WB_valid), 32'd0);
    chk("doneflush.idle", 32'(div_ready), 32'd1);

    // Back-pressure with a pending request: stall and stable result
    s0 = n_start;
    issue(vecs[2], "bp");
    wait_wb(vecs[2], "bp", s0);
    ISS_div_en = 1'b1; ISS_a = 32'd55; ISS_b = 32'd5; ISS_rd = 5'd17;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.stall", 32'(div_stall), 32'd1);
      chk("bp.valid", 32'(WB_valid), 32'd1);
      chk("bp.data", WB_data, vecs[2].exp);
      chk("bp.rd", 32'(WB_rd), 32'(vecs[2].rd));
    end
    ISS_div_en = 1'b0;
    #1;
    chk("bp.stall_off", 32'(div_stall), 32'd0);
    handshake("bp");

    // Reset in the middle of RUN
    s0 = n_start;
    issue(vecs[2], "midrst");
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midrst.start", 32'(div_start), 32'd0);
    chk("midrst.wb_valid", 32'(WB_valid), 32'd0);
    chk("midrst.div_a", div_a, 32'd0);
    chk("midrst.div_b", div_b, 32'd0);
    chk("midrst.wb_data", WB_data, 32'd0);
    chk("midrst.ready", 32'(div_ready), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      saw |= WB_valid;
    end
    chk("midrst.no_wb", 32'(saw), 32'd0);
    chk("midrst.one_start", 32'(n_start - s0), 32'd1);
    run_op(vecs[0], "postrst", 1);

    // Randomized ops against the reference model
    for (int i = 0; i < 30; i++) begin
      v.a  = $urandom;
      v.b  = $urandom;
      v.s  = 1'($urandom);
      v.op = 1'($urandom);
      v.rd = 5'($urandom);
      case ($urandom_range(0, 7))
        0: v.b = 32'd0;
        1: begin v.a = 32'h8000_0000; v.b = 32'hFFFF_FFFF; end
        2: v.b = 32'($urandom_range(1, 15));
        3: v.b = 32'hFFFF_FFFF;
        default: ;
      endcase
      r      = ref_div(v.a, v.b, v.s);
      v.exp  = v.op ? r[31:0] : r[63:32];
      v.fast = (v.b == 32'd0) || (v.s && v.a == 32'h8000_0000 && v.b == 32'hFFFF_FFFF);
      run_op(v, $sformatf("rnd%0d", i), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Sequencing controller between the issue stage (ISS_*) and the fixed-latency iterative 32-bit divider.
- Accepts one div/mod op at a time, registers operands, pulses the divider start and counts its latency.
- Resolves divide-by-zero and signed overflow on a 1-cycle fast path.
- Selects quotient or remainder and holds the result for writeback under a valid/ready handshake; stalls issue and honours pipeline flush.

Parameters:
- DIV_CYCLES, 32, divider latency in cycles from div_start to result valid on div_quo/div_rem.
- TAG_W, 5, destination register tag width.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- ISS_div_en  in  1  request valid
- ISS_a  in  32  dividend
- ISS_b  in  32  divisor
- ISS_div_signed  in  1  1 = signed op
- ISS_div_op  in  1  0 = quotient, 1 = remainder
- ISS_rd  in  TAG_W  destination tag
- ISS_flush  in  1  kill in-flight op
- div_ready  out  1  controller idle, can accept
- div_stall  out  1  issue must hold
- div_start  out  1  one-cycle start pulse to divider
- div_a, div_b  out  32  registered operands to divider
- div_signed  out  1  registered signedness
- div_quo, div_rem  in  32  divider results
- WB_valid  out  1  result valid
- WB_ready  in  1  writeback accepts
- WB_rd  out  TAG_W  result tag
- WB_data  out  32  result

Behaviour:
- Reset (async, rstn=0): state IDLE; counter 0; div_start, WB_valid = 0; div_a, div_b, WB_data = 0; WB_rd = 0; div_signed = 0. Reset mid-operation discards everything. No WB after release.
- States: IDLE, RUN, DONE.
- div_ready = (state==IDLE).
- div_stall = ISS_div_en & ~div_ready (combinational).
- Accept: edge where IDLE & ISS_div_en & ~ISS_flush.
  - Register operands, signed, op and rd.
  - Special case detection, evaluated on ISS_a/ISS_b:
    - b==0: quo = 0xFFFF_FFFF, rem = a (signed and unsigned).
    - signed & a==0x8000_0000 & b==0xFFFF_FFFF: quo = 0x8000_0000, rem = 0.
  - Special case: go directly to DONE with the selected value. WB_valid is high 1 cycle after accept. No div_start.
  - Otherwise go to RUN. div_start = 1 for exactly the first RUN cycle. Counter is cleared.
- RUN: counter increments every cycle. In the cycle where counter == DIV_CYCLES-1, capture div_quo or div_rem per op into WB_data and go to DONE. WB_valid rises DIV_CYCLES+1 cycles after the accept edge.
- Counter width is clog2(DIV_CYCLES+1). It never wraps: it is cleared on entry to RUN.
- DONE: WB_valid = 1. WB_data and WB_rd are stable while WB_valid & ~WB_ready. On WB_valid & WB_ready: go to IDLE, WB_valid = 0. A new request is accepted no earlier than the cycle after handshake (no back-to-back).
- Flush:
  - In RUN or DONE: go to IDLE next edge, WB_valid = 0, result dropped. The divider output is ignored; the next div_start restarts the divider.
  - In IDLE simultaneous with ISS_div_en: flush wins, no accept.
  - In DONE simultaneous with WB_ready: flush wins, no handshake counted.
- Signed results: quotient truncates toward zero; remainder takes the dividend's sign. These are produced by the divider; the controller passes them through unchanged.
- Operands on ISS_* are don't-care outside the accept edge.

Test Plan:
- Unsigned, rd=3: 0x0000_0100 / 0x0000_0011, op=0 → div_start one cycle, WB_valid after 33 cycles, WB_data = 0x0000_000F, WB_rd = 3. Repeat with op=1 → WB_data = 0x0000_0001.
- Signed: 0x8A73_2000 / 0xFFFF_F567, op=0 → 0x000B_1794. Repeat with op=1 → 0xFFFF_FF74.
- Divide by zero: a = 0x0000_1234, b = 0, op=0 → no div_start, WB_valid 1 cycle after accept, data 0xFFFF_FFFF. Repeat with op=1 → 0x0000_1234.
- Signed overflow: 0x8000_0000 / 0xFFFF_FFFF, signed, op=0 → fast path, WB_data = 0x8000_0000. Repeat with op=1 → 0x0000_0000. Repeat unsigned → normal RUN path, quo = 0.
- Flush: ISS_flush asserted in RUN cycle 10 → never WB_valid, div_ready high next cycle. A new op issued immediately completes correctly after DIV_CYCLES+1 cycles.
- Back-pressure and reset: hold WB_ready = 0 for 5 cycles in DONE → WB_data/WB_rd stable, div_stall high while ISS_div_en = 1. Separately, drop rstn mid-RUN → all outputs 0 immediately, IDLE after release.
